nfca_frame_scheduler: RTL

Sits between the TX command FIFO (the fifo_sync output) and the nfca_controller TX stream. It also sits between the nfca_controller RX report stream and uart_tx.
- Releases one PCD frame at a time to the controller.
- Enforces a guard time between the end of one response and the start of the next frame.
- Enforces a response timeout. On expiry it injects a synthetic "end with error" beat into the report stream, so the host always receives exactly one terminator per frame.
- Keeps saturating frame and timeout statistics.

---
 rtl/nfca_sched_pkg.sv | 28 ++
 rtl/nfca_frame_scheduler_if.sv | 48 ++++
 rtl/nfca_sched_timer.sv | 28 ++
 rtl/nfca_frame_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/nfca_sched_pkg.sv
// Shared types and constants for the NFC-A frame scheduler: FSM encoding,
// report-beat layout and the synthetic timeout terminator.
package nfca_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2,
    GUARD     = 2'd3
  } sched_state_e;

  localparam int RPT_W = 8 + 4 + 1 + 1;

  typedef struct packed {
    logic [7:0] tdata;
    logic [3:0] tdatab;
    logic       tend;
    logic       terr;
  } rpt_beat_t;

  // End-with-error beat injected when the card never answers
  localparam rpt_beat_t INJ_BEAT = {8'h00, 4'h0, 1'b1, 1'b1};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nfca_frame_scheduler_if.sv
// Stream bundle around the frame scheduler: FIFO-side TX input, controller-side
// TX output, controller report input and report output to the UART formatter.
interface nfca_frame_scheduler_if;

  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic [3:0] s_tdatab;
  logic       s_tlast;

  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic [3:0] m_tdatab;
  logic       m_tlast;

  logic       rx_tvalid;
  logic [7:0] rx_tdata;
  logic [3:0] rx_tdatab;
  logic       rx_tend;
  logic       rx_terr;

  logic       o_tvalid;
  logic [7:0] o_tdata;
  logic [3:0] o_tdatab;
  logic       o_tend;
  logic       o_terr;

  // slave: the scheduler; master: the surrounding FIFO/controller/UART side
  modport slave (
    input  s_tvalid, s_tdata, s_tdatab, s_tlast,
    output s_tready,
    output m_tvalid, m_tdata, m_tdatab, m_tlast,
    input  m_tready,
    input  rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr,
    output o_tvalid, o_tdata, o_tdatab, o_tend, o_terr
  );

  modport master (
    output s_tvalid, s_tdata, s_tdatab, s_tlast,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tdatab, m_tlast,
    output m_tready,
    output rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr,
    input  o_tvalid, o_tdata, o_tdatab, o_tend, o_terr
  );

endinterface

// File: rtl/nfca_sched_timer.sv
// Loadable down-counter shared by the guard and response-timeout phases.
// Load has priority over decrement; the count stops at zero.
module nfca_sched_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nfca_frame_scheduler.sv
// Releases one PCD frame at a time to the NFC-A controller, enforces the
// post-response guard time and response timeout, and keeps frame statistics.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in flight; a waiting FIFO beat starts SEND
// SEND      | FIFO stream passed through to the controller until tlast
// WAIT_RESP | waiting for the report end marker, timeout timer running
// GUARD     | fixed idle gap before the next frame may start
module nfca_frame_scheduler
  import nfca_sched_pkg::*;
#(
  parameter int GUARD_CYCLES   = 8136,     // must be >= 1
  parameter int TIMEOUT_CYCLES = 1627200,
  parameter int CNT_W          = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  nfca_frame_scheduler_if.slave bus,
  output logic                  busy,
  output logic                  timeout_pulse,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           timeout_cnt
);

  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             inc_frame, inject;
  logic             s_ready, m_valid;
  logic [RPT_W-1:0] rx_vec;
  rpt_beat_t        rx_beat, o_beat_q;
  logic             o_valid_q;

  nfca_sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = TO_LOAD;
    tmr_dec   = 1'b0;
    inc_frame = 1'b0;
    inject    = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_tvalid) state_d = SEND;
      end
      SEND: begin
        m_valid = bus.s_tvalid;
        s_ready = bus.m_tready;
        if (bus.s_tvalid && bus.m_tready && bus.s_tlast) begin
          state_d   = WAIT_RESP;
          tmr_load  = 1'b1;
          tmr_val   = TO_LOAD;
          inc_frame = 1'b1;
        end
      end
      WAIT_RESP: begin
        // A real end marker beats a coinciding expiry, so no double terminator
        if (bus.rx_tvalid && bus.rx_tend) begin
          state_d  = GUARD;
          tmr_load = 1'b1;
          tmr_val  = GD_LOAD;
        end else if (bus.rx_tvalid) begin
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
        end else if (tmr_zero) begin
          state_d  = GUARD;
          tmr_load = 1'b1;
          tmr_val  = GD_LOAD;
          inject   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      GUARD: begin
        if (tmr_zero) state_d = IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_tready = s_ready;
  assign bus.m_tvalid = m_valid;
  assign bus.m_tdata  = bus.s_tdata;
  assign bus.m_tdatab = bus.s_tdatab;
  assign bus.m_tlast  = bus.s_tlast;

  assign busy = (state_q == SEND) || (state_q == WAIT_RESP);

  assign rx_vec  = {bus.rx_tdata, bus.rx_tdatab, bus.rx_tend, bus.rx_terr};
  assign rx_beat = rx_vec;

  // Report path: one register stage, data fields hold between beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q     <= 1'b0;
      o_beat_q      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      o_valid_q     <= bus.rx_tvalid | inject;
      timeout_pulse <= inject;
      if (bus.rx_tvalid) begin
        o_beat_q <= rx_beat;
      end else if (inject) begin
        o_beat_q <= INJ_BEAT;
      end
    end
  end

  assign bus.o_tvalid = o_valid_q;
  assign bus.o_tdata  = o_beat_q.tdata;
  assign bus.o_tdatab = o_beat_q.tdatab;
  assign bus.o_tend   = o_beat_q.tend;
  assign bus.o_terr   = o_beat_q.terr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= 16'd0;
      timeout_cnt <= 16'd0;
    end else begin
      if (inc_frame) frame_cnt   <= sat_inc16(frame_cnt);
      if (inject)    timeout_cnt <= sat_inc16(timeout_cnt);
    end
  end

endmodule
